hawk_att_lkup_rdr: RTL and testbench
====================================

Name: hawk_att_lkup_rdr

Overview:
- Fetch stage directly upstream of the translation/decode logic in hawk_pgrd_mngr.
- Accepts one ATT lookup request at a time and issues a single-beat AXI4 read for the 64-byte ATT cache line holding the entry.
- Extracts the 64-bit ATT entry from that line, applies the zero-page-detect (ZPD) count rule, and returns one translation response.
- Keeps a one-line ATT cache so that back-to-back lookups to the same line skip the AXI read.

Parameters:
AXI_ADDR_W, 64, AXI address width
AXI_DATA_W, 512, AXI data width (one 64-byte line)
AXI_ID_W, 4, AXI ID width
ATT_ID_W, 22, ATT entry id width (ids are 1-based)
ATT_START, 64'h0, byte base address of the ATT in memory
RD_ID, 4'h1, ARID driven on every read

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  lookup request valid
req_ready_o  out  1  block can accept a request
req_att_id_i  in  ATT_ID_W  1-based ATT entry id
req_zero_wr_i  in  1  request is a zero-block write
inv_i  in  1  invalidate the cached line (ATT was written elsewhere)
axi_arvalid_o  out  1  AR valid
axi_arready_i  in  1  AR ready
axi_araddr_o  out  AXI_ADDR_W  line address
axi_arid_o  out  AXI_ID_W  = RD_ID
axi_arlen_o  out  8  constant 0
axi_rvalid_i  in  1  R valid
axi_rready_o  out  1  R ready
axi_rdata_i  in  AXI_DATA_W  line data
axi_rresp_i  in  2  response code
axi_rlast_i  in  1  last beat
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_ppa_o  out  AXI_ADDR_W  way<<12
rsp_sts_o  out  2  entry status
rsp_zpd_cnt_o  out  8  new ZPD count
rsp_zpd_update_o  out  1  ZPD count must be written back
rsp_err_o  out  1  AXI error or illegal id

Behaviour:
- Reset state (async, rst_ni=0): FSM in IDLE, cache invalid.
  - Output reset values: req_ready_o=1, axi_arvalid_o=0, axi_rready_o=0, rsp_valid_o=0; all response data 0.
- Address and slot:
  - line_idx = (id-1)>>3.
  - axi_araddr_o = ATT_START + (line_idx<<6).
  - slot = (id-1)[2:0]; entry = rdata[64*slot +: 64].
- Entry layout: sts=[63:62], zpd_cnt=[61:54], way=[31:0]; rsp_ppa_o = zero-extended way<<12.
- ZPD rule, evaluated in priority order:
  1. zero_wr=1: cnt = min(cnt+1, 8'hFF), update=1.
  2. cnt!=0: cnt=0, update=1.
  3. Otherwise: cnt unchanged, update=0.
- FSM states: IDLE, AR, RWAIT, RESP.
  - IDLE: req_ready_o=1. On req_valid_i, capture id and zero_wr, then:
    - id==0: go to RESP with rsp_err_o=1 and all other response data 0.
    - Cache valid and line_idx matches the tag: hit. Decode from the cached line and go to RESP the next cycle (no AXI traffic).
    - Otherwise: go to AR.
  - AR: axi_arvalid_o=1 and address held stable until axi_arready_i, then go to RWAIT.
  - RWAIT: axi_rready_o=1. On axi_rvalid_i:
    - rresp==0: store line and tag, mark cache valid, decode, go to RESP.
    - rresp!=0: rsp_err_o=1, cache invalid, go to RESP.
    - rlast is expected to be 1; the beat is treated as final regardless.
  - RESP: rsp_valid_o=1 with data held stable until rsp_ready_i, then go to IDLE.
- Latency:
  - Hit: rsp_valid_o 2 cycles after request acceptance.
  - Miss with arready=1 and rvalid the cycle after AR: 4 cycles.
- Only one outstanding request; req_ready_o=0 in every state except IDLE.
- inv_i clears the cache valid bit in any state.
  - If inv_i coincides with a fill in RWAIT, invalidation wins: the response is still returned but the line is not cached.
  - If inv_i coincides with a hit decision in IDLE, the hit proceeds and the line becomes invalid afterwards.
- The block does not write back ZPD counts; it only reports them.
- Reset mid-transaction returns to IDLE at once and drops the in-flight AR/R. The system must reset the AXI slave together with this block.

Test Plan:
- Miss decode: id=10, line has slot1 entry sts=2, cnt=0, way=0x5, zero_wr=0 -> araddr=ATT_START+0x40, arlen=0; rsp ppa=0x5000, sts=2, cnt=0, update=0.
- Hit: id=11 right after the previous case, entry slot2 cnt=3, zero_wr=0 -> no AR issued; rsp 2 cycles after acceptance with cnt=0, update=1.
- Saturation: entry cnt=8'hFF with zero_wr=1 -> cnt=8'hFF, update=1; cnt=7 with zero_wr=1 -> cnt=8, update=1.
- Errors: rresp=2'b10 -> rsp_err_o=1 and the next lookup to the same line re-issues AR; id=0 -> immediate err response with no AR.
- Backpressure and invalidation: arready held low 5 cycles and rsp_ready_i low 3 cycles -> araddr and rsp data stable throughout; inv_i asserted in the rvalid cycle -> the following same-line request misses.
- Async reset asserted in RWAIT -> all outputs at reset values immediately; after release a new request completes normally.

Source files
------------

// File: rtl/hawk_att_lkup_rdr_if.sv
// AXI4 read-address/read-data channel bundle between the ATT lookup reader and memory.
interface hawk_att_lkup_rdr_if #(
    parameter int unsigned AXI_ADDR_W = 64,
    parameter int unsigned AXI_DATA_W = 512,
    parameter int unsigned AXI_ID_W   = 4
);
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_ID_W-1:0]   arid;
    logic [7:0]            arlen;
    logic                  rvalid;
    logic                  rready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, araddr, arid, arlen, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/hawk_att_lkup_rdr.sv
// ATT lookup reader: fetches the 64-byte ATT line over AXI (or from a one-line cache),
// extracts the entry, applies the zero-page-detect count rule and returns one response.
module hawk_att_lkup_rdr #(
    parameter int unsigned           AXI_ADDR_W = 64,
    parameter int unsigned           AXI_DATA_W = 512,
    parameter int unsigned           AXI_ID_W   = 4,
    parameter int unsigned           ATT_ID_W   = 22,
    parameter logic [AXI_ADDR_W-1:0] ATT_START  = '0,
    parameter logic [AXI_ID_W-1:0]   RD_ID      = AXI_ID_W'(1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ATT_ID_W-1:0]   req_att_id_i,
    input  logic                  req_zero_wr_i,
    input  logic                  inv_i,
    hawk_att_lkup_rdr_if.master   axi,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [AXI_ADDR_W-1:0] rsp_ppa_o,
    output logic [1:0]            rsp_sts_o,
    output logic [7:0]            rsp_zpd_cnt_o,
    output logic                  rsp_zpd_update_o,
    output logic                  rsp_err_o
);
    localparam int unsigned LINE_W = ATT_ID_W - 3;

    // StDec is the cycle in which the selected line is decoded into the response registers.
    typedef enum logic [2:0] {StIdle, StAr, StRwait, StDec, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    zero_wr_q;
    logic [2:0]              slot_q;
    logic [LINE_W-1:0]       line_idx_q;
    logic [LINE_W-1:0]       tag_q;
    logic                    cache_vld_q;
    logic [AXI_DATA_W-1:0]   line_q;
    logic [AXI_ADDR_W-1:0]   rsp_ppa_q;
    logic [1:0]              rsp_sts_q;
    logic [7:0]              rsp_cnt_q;
    logic                    rsp_upd_q;
    logic                    rsp_err_q;

    logic [ATT_ID_W-1:0]     id_m1;
    logic [LINE_W-1:0]       req_line;
    logic                    req_id_zero;
    logic                    hit;
    logic [63:0]             entry;
    logic [7:0]              dec_cnt;
    logic                    dec_upd;
    logic                    unused_bits;

    assign id_m1       = req_att_id_i - ATT_ID_W'(1);
    assign req_line    = id_m1[ATT_ID_W-1:3];
    assign req_id_zero = (req_att_id_i == '0);
    assign hit         = cache_vld_q && (req_line == tag_q);

    // Entry decode and ZPD rule; zero-block write has priority over clearing.
    always_comb begin
        entry   = line_q[{slot_q, 6'd0} +: 64];
        dec_cnt = entry[61:54];
        dec_upd = 1'b0;
        if (zero_wr_q) begin
            dec_cnt = (entry[61:54] == 8'hFF) ? 8'hFF : entry[61:54] + 8'd1;
            dec_upd = 1'b1;
        end else if (entry[61:54] != 8'd0) begin
            dec_cnt = 8'd0;
            dec_upd = 1'b1;
        end
    end

    assign unused_bits = ^{entry[53:32], axi.rlast};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (req_id_zero) begin
                        state_d = StResp;
                    end else if (hit) begin
                        state_d = StDec;
                    end else begin
                        state_d = StAr;
                    end
                end
            end
            StAr: begin
                if (axi.arready) state_d = StRwait;
            end
            StRwait: begin
                if (axi.rvalid) state_d = (axi.rresp == 2'b00) ? StDec : StResp;
            end
            StDec: state_d = StResp;
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            zero_wr_q   <= 1'b0;
            slot_q      <= '0;
            line_idx_q  <= '0;
            tag_q       <= '0;
            cache_vld_q <= 1'b0;
            line_q      <= '0;
            rsp_ppa_q   <= '0;
            rsp_sts_q   <= '0;
            rsp_cnt_q   <= '0;
            rsp_upd_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        zero_wr_q  <= req_zero_wr_i;
                        slot_q     <= id_m1[2:0];
                        line_idx_q <= req_line;
                        if (req_id_zero) begin
                            rsp_ppa_q <= '0;
                            rsp_sts_q <= '0;
                            rsp_cnt_q <= '0;
                            rsp_upd_q <= 1'b0;
                            rsp_err_q <= 1'b1;
                        end
                    end
                end
                StRwait: begin
                    if (axi.rvalid) begin
                        if (axi.rresp == 2'b00) begin
                            line_q      <= axi.rdata;
                            tag_q       <= line_idx_q;
                            cache_vld_q <= 1'b1;
                        end else begin
                            cache_vld_q <= 1'b0;
                            rsp_ppa_q   <= '0;
                            rsp_sts_q   <= '0;
                            rsp_cnt_q   <= '0;
                            rsp_upd_q   <= 1'b0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                StDec: begin
                    rsp_ppa_q <= {{(AXI_ADDR_W-44){1'b0}}, entry[31:0], 12'h000};
                    rsp_sts_q <= entry[63:62];
                    rsp_cnt_q <= dec_cnt;
                    rsp_upd_q <= dec_upd;
                    rsp_err_q <= 1'b0;
                end
                default: ;
            endcase
            // Invalidate overrides a same-cycle fill; the line is still used for this response.
            if (inv_i) cache_vld_q <= 1'b0;
        end
    end

    assign req_ready_o      = (state_q == StIdle);
    assign axi.arvalid      = (state_q == StAr);
    assign axi.araddr       = ATT_START + {{(AXI_ADDR_W-LINE_W-6){1'b0}}, line_idx_q, 6'd0};
    assign axi.arid         = RD_ID;
    assign axi.arlen        = 8'd0;
    assign axi.rready       = (state_q == StRwait);
    assign rsp_valid_o      = (state_q == StResp);
    assign rsp_ppa_o        = rsp_ppa_q;
    assign rsp_sts_o        = rsp_sts_q;
    assign rsp_zpd_cnt_o    = rsp_cnt_q;
    assign rsp_zpd_update_o = rsp_upd_q;
    assign rsp_err_o        = rsp_err_q;
endmodule

// File: tb/tb_hawk_att_lkup_rdr.sv
// Directed-vector bench for hawk_att_lkup_rdr with a small AXI line memory model.
module tb_hawk_att_lkup_rdr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [21:0] req_id = '0;
    logic        req_zwr = 1'b0;
    logic        inv = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_ppa;
    logic [1:0]  rsp_sts;
    logic [7:0]  rsp_cnt;
    logic        rsp_upd;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    hawk_att_lkup_rdr_if #(.AXI_ADDR_W(64), .AXI_DATA_W(512), .AXI_ID_W(4)) axi_bus ();

    hawk_att_lkup_rdr dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_att_id_i     (req_id),
        .req_zero_wr_i    (req_zwr),
        .inv_i            (inv),
        .axi              (axi_bus),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_ppa_o        (rsp_ppa),
        .rsp_sts_o        (rsp_sts),
        .rsp_zpd_cnt_o    (rsp_cnt),
        .rsp_zpd_update_o (rsp_upd),
        .rsp_err_o        (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] id;
        logic        zwr;
        logic [1:0]  rresp;
        bit          miss;
        logic [63:0] addr;
        int          lat;
        logic [63:0] ppa;
        logic [1:0]  sts;
        logic [7:0]  cnt;
        logic        upd;
        logic        err;
    } vec_t;

    vec_t        vecs [12];
    logic [63:0] ent [8][8];

    function automatic logic [63:0] mk_ent(logic [1:0] sts, logic [7:0] cnt, logic [31:0] way);
        return {sts, cnt, 22'h2AAAAA, way};
    endfunction

    function automatic logic [511:0] line_of(int idx);
        logic [511:0] l;
        for (int s = 0; s < 8; s++) l[64*s +: 64] = ent[idx][s];
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one lookup from an idle negedge, serve AXI, then check and retire the response.
    task automatic run_vec(input int n, input vec_t v);
        int    cyc;
        int    ar_cnt;
        string p;
        p = $sformatf("v%0d_", n);
        chk({p, "req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_id    = v.id;
        req_zwr   = v.zwr;
        cyc       = 0;
        ar_cnt    = 0;
        do begin
            @(negedge clk);
            cyc++;
            req_valid         = 1'b0;
            axi_bus.arready   = 1'b0;
            axi_bus.rvalid    = 1'b0;
            if (axi_bus.arvalid) begin
                ar_cnt++;
                chk({p, "araddr"}, axi_bus.araddr, v.addr);
                chk({p, "arid_arlen"}, {52'd0, axi_bus.arid, axi_bus.arlen}, {52'd0, 4'h1, 8'h00});
                axi_bus.arready = 1'b1;
            end
            if (axi_bus.rready) begin
                axi_bus.rvalid = 1'b1;
                axi_bus.rdata  = line_of(int'(v.addr[8:6]));
                axi_bus.rresp  = v.rresp;
                axi_bus.rlast  = 1'b1;
            end
        end while (!rsp_valid && cyc < 40);
        chk({p, "rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({p, "latency"}, 64'(cyc), 64'(v.lat));
        chk({p, "ar_count"}, 64'(ar_cnt), v.miss ? 64'd1 : 64'd0);
        chk({p, "ppa"}, rsp_ppa, v.ppa);
        chk({p, "sts_cnt_upd_err"}, {52'd0, rsp_sts, rsp_cnt, rsp_upd, rsp_err},
            {52'd0, v.sts, v.cnt, v.upd, v.err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({p, "rsp_retired"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "req_ready"}, 64'(req_ready), 64'd1);
        chk({p, "arvalid_rready"}, {62'd0, axi_bus.arvalid, axi_bus.rready}, 64'd0);
        chk({p, "rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({p, "rsp_data"}, rsp_ppa | {52'd0, rsp_sts, rsp_cnt, rsp_upd, rsp_err}, 64'd0);
    endtask

    initial begin
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rdata   = '0;
        axi_bus.rresp   = 2'b00;
        axi_bus.rlast   = 1'b0;
        for (int l = 0; l < 8; l++)
            for (int s = 0; s < 8; s++) ent[l][s] = 64'd0;
        ent[1][1] = mk_ent(2'd2, 8'd0,   32'h5);
        ent[1][2] = mk_ent(2'd1, 8'd3,   32'hABC);
        ent[1][3] = mk_ent(2'd3, 8'hFF,  32'h12345);
        ent[2][0] = mk_ent(2'd0, 8'd7,   32'hFFFF_FFFF);
        ent[2][7] = mk_ent(2'd1, 8'd0,   32'h77);
        ent[0][0] = mk_ent(2'd2, 8'd0,   32'h1);
        ent[0][7] = mk_ent(2'd3, 8'h10,  32'h2);
        ent[4][0] = mk_ent(2'd3, 8'd9,   32'h55);
        ent[4][1] = mk_ent(2'd1, 8'd0,   32'h9);
        ent[5][0] = mk_ent(2'd1, 8'h20,  32'h33);
        ent[5][1] = mk_ent(2'd2, 8'd0,   32'h44);
        ent[6][0] = mk_ent(2'd2, 8'd5,   32'hDEAD);

        //            id     zwr   rresp  miss  addr      lat  ppa                   sts   cnt    upd   err
        vecs[0]  = '{22'd10, 1'b0, 2'd0, 1'b1, 64'h40,  4, 64'h5000,            2'd2, 8'd0,  1'b0, 1'b0};
        vecs[1]  = '{22'd11, 1'b0, 2'd0, 1'b0, 64'h40,  2, 64'hABC000,          2'd1, 8'd0,  1'b1, 1'b0};
        vecs[2]  = '{22'd12, 1'b1, 2'd0, 1'b0, 64'h40,  2, 64'h12345000,        2'd3, 8'hFF, 1'b1, 1'b0};
        vecs[3]  = '{22'd17, 1'b1, 2'd0, 1'b1, 64'h80,  4, 64'hFFFF_FFFF_000,   2'd0, 8'd8,  1'b1, 1'b0};
        vecs[4]  = '{22'd24, 1'b0, 2'd0, 1'b0, 64'h80,  2, 64'h77000,           2'd1, 8'd0,  1'b0, 1'b0};
        vecs[5]  = '{22'd1,  1'b1, 2'd0, 1'b1, 64'h0,   4, 64'h1000,            2'd2, 8'd1,  1'b1, 1'b0};
        vecs[6]  = '{22'd0,  1'b0, 2'd0, 1'b0, 64'h0,   1, 64'h0,               2'd0, 8'd0,  1'b0, 1'b1};
        vecs[7]  = '{22'd8,  1'b0, 2'd0, 1'b0, 64'h0,   2, 64'h2000,            2'd3, 8'd0,  1'b1, 1'b0};
        vecs[8]  = '{22'd33, 1'b0, 2'd2, 1'b1, 64'h100, 3, 64'h0,               2'd0, 8'd0,  1'b0, 1'b1};
        vecs[9]  = '{22'd34, 1'b0, 2'd0, 1'b1, 64'h100, 4, 64'h9000,            2'd1, 8'd0,  1'b0, 1'b0};
        vecs[10] = '{22'd42, 1'b0, 2'd0, 1'b1, 64'h140, 4, 64'h44000,           2'd2, 8'd0,  1'b0, 1'b0};
        vecs[11] = '{22'd49, 1'b0, 2'd0, 1'b1, 64'h180, 4, 64'hDEAD000,         2'd2, 8'd0,  1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // AR and response backpressure, with invalidate landing on the fill beat.
        req_valid = 1'b1;
        req_id    = 22'd41;
        req_zwr   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_arvalid", 64'(axi_bus.arvalid), 64'd1);
            chk("bp_araddr", axi_bus.araddr, 64'h140);
            @(negedge clk);
        end
        axi_bus.arready = 1'b1;
        @(negedge clk);
        axi_bus.arready = 1'b0;
        chk("bp_rready", 64'(axi_bus.rready), 64'd1);
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = line_of(5);
        axi_bus.rresp  = 2'b00;
        axi_bus.rlast  = 1'b1;
        inv            = 1'b1;
        @(negedge clk);
        axi_bus.rvalid = 1'b0;
        inv            = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_ppa", rsp_ppa, 64'h33000);
            chk("bp_rsp_fields", {52'd0, rsp_sts, rsp_cnt, rsp_upd, rsp_err},
                {52'd0, 2'd1, 8'd0, 1'b1, 1'b0});
            if (i < 3) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        run_vec(10, vecs[10]);

        // Asynchronous reset while waiting for read data.
        req_valid = 1'b1;
        req_id    = 22'd49;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_arvalid", 64'(axi_bus.arvalid), 64'd1);
        axi_bus.arready = 1'b1;
        @(negedge clk);
        axi_bus.arready = 1'b0;
        chk("rst_rready", 64'(axi_bus.rready), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset_");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(11, vecs[11]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
